// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg.sv
// Shared types and constants for the NAND4 BIST sequencer.
// Optional comparator self-check: GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN.
package gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC    = 16;
  localparam int VEC_W      = 4;
  localparam int ERR_W      = 5;
  localparam int SETTLE_MAX = 255;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_bist_if.sv
// Signal bundle between the BIST sequencer (slave) and its environment (master).
// Injection ports exist only with GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN.
interface gf180mcu_fd_sc_mcu7t5v0__nand4_bist_if;
  import gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg::*;

  // START is a level request with no ready: it is taken on any rising edge
  // where the sequencer sits in IDLE or DONE and is ignored otherwise.
  logic             START;
  logic             ZN_OBS;
  logic             A1, A2, A3, A4;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [ERR_W-1:0] ERR_CNT;
  logic [VEC_W-1:0] FAIL_VEC;
  state_t           state_dbg;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
  logic             INJ_EN;
  logic [VEC_W-1:0] INJ_VEC;

  modport master (output START, ZN_OBS, INJ_EN, INJ_VEC,
                  input  A1, A2, A3, A4, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, state_dbg);
  modport slave  (input  START, ZN_OBS, INJ_EN, INJ_VEC,
                  output A1, A2, A3, A4, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, state_dbg);
`else
  modport master (output START, ZN_OBS,
                  input  A1, A2, A3, A4, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, state_dbg);
  modport slave  (input  START, ZN_OBS,
                  output A1, A2, A3, A4, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, state_dbg);
`endif

endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_bist_golden.sv
// Combinational expected-ZN model of an ideal NAND4 for the vector on the A pins.
// With GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN one chosen vector's expectation is inverted.
module gf180mcu_fd_sc_mcu7t5v0__nand4_bist_golden
  import gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             zn_exp
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
  ,
  input  logic             inj_en,
  input  logic [VEC_W-1:0] inj_vec
`endif
);

`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
  assign zn_exp = (~&vec) ^ (inj_en && (vec == inj_vec));
`else
  assign zn_exp = ~&vec;
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_bist.sv
// BIST sequencer: walks all 16 NAND4 input vectors, compares ZN against the golden model.
// Optional comparator self-check: GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN.
module gf180mcu_fd_sc_mcu7t5v0__nand4_bist
  import gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__nand4_bist_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_SAT   = ERR_W'(NUM_VEC);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] a_q;
  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_cnt;
  logic [VEC_W-1:0] fail_vec;
  logic             pass;
  logic             zn_exp;
  logic             mismatch;
  logic             start_ok;

`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
  logic             inj_en_q;
  logic [VEC_W-1:0] inj_vec_q;

  gf180mcu_fd_sc_mcu7t5v0__nand4_bist_golden u_golden (
    .vec     (a_q),
    .zn_exp  (zn_exp),
    .inj_en  (inj_en_q),
    .inj_vec (inj_vec_q)
  );
`else
  gf180mcu_fd_sc_mcu7t5v0__nand4_bist_golden u_golden (
    .vec    (a_q),
    .zn_exp (zn_exp)
  );
`endif

  assign mismatch = (bus.ZN_OBS != zn_exp);
  assign start_ok = bus.START && ((state == IDLE) || (state == DONE));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.START) state_nxt = SETTLE;
      SETTLE:     if (cnt == CNT_W'(1)) state_nxt = CHECK;
      CHECK:      state_nxt = (vec == LAST_VEC) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vec      <= '0;
      a_q      <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      pass     <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
      inj_en_q  <= 1'b0;
      inj_vec_q <= '0;
`endif
    end else if (start_ok) begin
      vec      <= '0;
      a_q      <= '0;
      cnt      <= SETTLE_LD;
      err_cnt  <= '0;
      fail_vec <= '0;
      pass     <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
      inj_en_q  <= bus.INJ_EN;
      inj_vec_q <= bus.INJ_VEC;
`endif
    end else if (state == SETTLE) begin
      cnt <= cnt - CNT_W'(1);
    end else if (state == CHECK) begin
      if (mismatch) begin
        if (err_cnt < ERR_SAT) err_cnt <= err_cnt + ERR_W'(1);
        if (err_cnt == '0)     fail_vec <= vec;
      end
      // PASS looks at this vector's compare too, not just the registered count.
      if (vec == LAST_VEC) begin
        a_q  <= '0;
        pass <= (err_cnt == '0) && !mismatch;
      end else begin
        vec <= vec + VEC_W'(1);
        a_q <= vec + VEC_W'(1);
        cnt <= SETTLE_LD;
      end
    end
  end

  assign bus.A1        = a_q[0];
  assign bus.A2        = a_q[1];
  assign bus.A3        = a_q[2];
  assign bus.A4        = a_q[3];
  assign bus.BUSY      = (state == SETTLE) || (state == CHECK);
  assign bus.DONE      = (state == DONE);
  assign bus.PASS      = pass;
  assign bus.ERR_CNT   = err_cnt;
  assign bus.FAIL_VEC  = fail_vec;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nand4_bist.sv
// Self-checking bench: a NAND4 cell model with a per-vector fault mask drives ZN_OBS,
// results are predicted from the mask alone and checked through a scoreboard queue.
module tb_gf180mcu_fd_sc_mcu7t5v0__nand4_bist;
  import gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg::*;

  localparam int SETTLE_CYC = 2;
  localparam int LAT        = NUM_VEC * (SETTLE_CYC + 1);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [15:0] fault_mask = 16'h0;
  logic [9:0]  exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu7t5v0__nand4_bist_if bus ();

  gf180mcu_fd_sc_mcu7t5v0__nand4_bist #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Cell under test: ideal NAND4 with ZN flipped on every vector whose mask bit is set.
  logic [3:0] a_pins;
  assign a_pins     = {bus.A4, bus.A3, bus.A2, bus.A1};
  assign bus.ZN_OBS = (~&a_pins) ^ fault_mask[a_pins];

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: from the set of vectors that will mismatch, derive {PASS, ERR_CNT, FAIL_VEC}.
  function automatic logic [9:0] ref_result(input logic [15:0] mism);
    int cnt;
    int first;
    cnt   = 0;
    first = -1;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (mism[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    if (cnt > NUM_VEC) cnt = NUM_VEC;
    return {(cnt == 0), 5'(cnt), 4'(first)};
  endfunction

  function automatic logic [9:0] results();
    return {bus.PASS, bus.ERR_CNT, bus.FAIL_VEC};
  endfunction

  task automatic check_reset_values(input string tag);
    check(tag, {a_pins, bus.BUSY, bus.DONE, bus.PASS, bus.ERR_CNT, bus.FAIL_VEC}, 32'h0);
    check({tag, "_state"}, 32'(bus.state_dbg), 32'(IDLE));
  endtask

  task automatic drive_start(input logic inj_en, input logic [3:0] inj_vec);
    @(negedge CLK);
    bus.START = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
    bus.INJ_EN  = inj_en;
    bus.INJ_VEC = inj_vec;
`endif
    @(negedge CLK);
    bus.START = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
    // Only the START-edge values matter; scramble them afterwards.
    bus.INJ_EN  = 1'($urandom_range(0, 1));
    bus.INJ_VEC = 4'($urandom_range(0, 15));
`endif
  endtask

  // One full run; noise adds ignored START pulses while the run is busy.
  task automatic run_test(input string tag, input logic [15:0] mask, input logic inj_en,
                          input logic [3:0] inj_vec, input bit noise);
    logic [15:0] inj_bit;
    logic [5:0]  exp_phase;
    fault_mask = mask;
    inj_bit    = inj_en ? (16'h1 << inj_vec) : 16'h0;
`ifndef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
    inj_bit = 16'h0;
`endif
    exp_q.push_back(ref_result(mask ^ inj_bit));
    drive_start(inj_en, inj_vec);
    check({tag, "_start_clr"}, {bus.DONE, results()}, 32'h0);
    for (int c = 0; c <= LAT; c++) begin
      if (c > 0) @(negedge CLK);
      exp_phase = {(c < LAT), (c >= LAT), (c < LAT) ? 4'(c / (SETTLE_CYC + 1)) : 4'h0};
      check({tag, "_phase"}, {bus.BUSY, bus.DONE, a_pins}, exp_phase);
      bus.START = (noise && c < LAT - 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    bus.START = 1'b0;
    check({tag, "_result"}, results(), exp_q.pop_front());
  endtask

  initial begin
    bus.START = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
    bus.INJ_EN  = 1'b0;
    bus.INJ_VEC = 4'h0;
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b0;

    run_test("ideal",    16'h0000, 1'b0, 4'h0, 1'b0);
    run_test("stuck1",   16'h8000, 1'b0, 4'h0, 1'b0);
    check("stuck1_const", results(), {1'b0, 5'd1, 4'hF});
    run_test("stuck0",   16'h7FFF, 1'b0, 4'h0, 1'b0);
    check("stuck0_const", results(), {1'b0, 5'd15, 4'h0});
    run_test("inverted", 16'hFFFF, 1'b0, 4'h0, 1'b1);
    check("inverted_const", results(), {1'b0, 5'd16, 4'h0});

    // Abort a faulty run with RST at cycle 20, then run clean.
    fault_mask = 16'hFFFF;
    drive_start(1'b0, 4'h0);
    for (int c = 1; c <= 20; c++) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_values("abort");
    RST = 1'b0;
    @(negedge CLK);
    check_reset_values("abort_hold");
    run_test("after_abort", 16'h0000, 1'b0, 4'h0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] m;
      m = 16'($urandom_range(0, 16'hFFFF));
      if (i == 0) m = 16'h0021;
      run_test("random", m, 1'b0, 4'h0, 1'b1);
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN
    run_test("inj5", 16'h0000, 1'b1, 4'h5, 1'b0);
    check("inj5_const", results(), {1'b0, 5'd1, 4'h5});
    run_test("inj_off", 16'h0000, 1'b0, 4'h5, 1'b0);
    check("inj_off_pass", 32'(bus.PASS), 32'h1);
    for (int i = 0; i < 4; i++)
      run_test("inj_rand", 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'b1);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nand4_bist.md
# gf180mcu_fd_sc_mcu7t5v0__nand4_bist

Built-in self-test sequencer for a NAND4 cell instance. It drives all 16 input combinations onto the cell's A1..A4 pins, waits a programmable settle time, samples ZN and compares it against the golden value ~(A1&A2&A3&A4). It reports pass/fail, the error count and the first failing vector. It sits beside a NAND4 cell under test in characterization and silicon-debug blocks and owns that cell's inputs while a run is active.

## Interface
- SETTLE_CYC, default 2: number of cycles a vector is held before ZN is sampled; legal range is 1..255.
- CLK  in  1  clock; every flop updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  run request; honoured only in IDLE or DONE.
- ZN_OBS  in  1  ZN of the cell under test.
- A1, A2, A3, A4  out  1 each  drive the cell's inputs; registered.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  high from run completion until the next accepted START or RST.
- PASS  out  1  valid while DONE is high; 1 means zero mismatches.
- ERR_CNT  out  5  mismatch count, range 0..16.
- FAIL_VEC  out  4  first failing vector {A4,A3,A2,A1}; 0 when there are no errors.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Reset state is IDLE.
- Reset values: A1..A4=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, vector index=0, settle counter=0.
- IDLE, START=1:
  - next state SETTLE; vec←0; {A4..A1}←0; counter←SETTLE_CYC.
  - ERR_CNT, FAIL_VEC and PASS are cleared.
- SETTLE:
  - the counter decrements each cycle.
  - when counter==1, next state is CHECK, so SETTLE lasts exactly SETTLE_CYC cycles.
- CHECK, one cycle:
  - mismatch = ZN_OBS != ~&{A4,A3,A2,A1}.
  - on a mismatch: ERR_CNT increments. If ERR_CNT was 0, FAIL_VEC←vec.
  - if vec==15: next state DONE, {A4..A1}←0, PASS←(no mismatch on any vector, including this one).
  - otherwise: vec←vec+1, A pins←vec+1, counter←SETTLE_CYC, next state SETTLE.
- DONE:
  - results are held.
  - START=1 restarts exactly as from IDLE. DONE drops and results clear on the same edge.
- START while BUSY is ignored and does not extend or restart the run.
- RST while BUSY aborts the run. All outputs take their reset values at that edge; no partial results are kept.
- ERR_CNT saturates at 16. 16 is reachable; 17 is not.

## Timing
- If START is accepted at edge k, vector 0 is on the A pins after edge k.
- Vector n is sampled in CHECK at edge k+(n+1)·(SETTLE_CYC+1).
- DONE=1 and BUSY=0 after edge k+16·(SETTLE_CYC+1). With the default SETTLE_CYC this is 48 cycles.
- BUSY=1 exactly in SETTLE and CHECK.
- A pins change only on the START edge and on CHECK edges. They are stable throughout SETTLE.
- ZN_OBS is sampled synchronously. Any synchronizer is the integrator's responsibility.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__NAND4_BIST_FAULT_INJ_EN.
- Defined:
  - adds inputs INJ_EN (1 bit) and INJ_VEC (4 bits), both sampled on the START edge.
  - when the sampled INJ_EN is 1, the expected value for vector INJ_VEC is inverted. A good cell then yields ERR_CNT=1, FAIL_VEC=INJ_VEC, PASS=0.
  - used to self-check the comparator.
- Undefined: the ports are absent and the comparison is the pure golden NAND4 check.

## Structure
- Package gf180mcu_fd_sc_mcu7t5v0__nand4_bist_pkg holds:
  - the state enum (IDLE/SETTLE/CHECK/DONE);
  - constants NUM_VEC=16, VEC_W=4, ERR_W=5;
  - the counter width derived from the SETTLE_CYC maximum (8 bits).
- One sub-module, gf180mcu_fd_sc_mcu7t5v0__nand4_bist_golden: a combinational expected-ZN model, with the injection XOR present under the macro.
- The cell under test is outside this block.

## Test plan
- Ideal NAND4 model on ZN_OBS, SETTLE_CYC=2, START pulse -> DONE at +48 cycles, PASS=1, ERR_CNT=0, FAIL_VEC=0, A pins back at 0.
- ZN stuck-at-1 -> ERR_CNT=1, FAIL_VEC=4'hF, PASS=0.
- ZN stuck-at-0 -> ERR_CNT=15, FAIL_VEC=4'h0, PASS=0.
- Inverted ZN (an AND4 cell) -> ERR_CNT=16 (saturation point), FAIL_VEC=0, PASS=0.
- RST asserted at cycle 20 of a run, then START -> all outputs at reset values after the RST edge; the fresh run completes 48 cycles after START. START pulses mid-run have no effect on run length.
- With the macro defined, INJ_EN=1, INJ_VEC=4'h5, ideal cell -> ERR_CNT=1, FAIL_VEC=4'h5, PASS=0. A second run with INJ_EN=0 -> PASS=1.
